fifo_wr_ctrl: RTL
=================

# fifo_wr_ctrl

Write-side controller for the asynchronous AXI-Stream FIFO, living entirely in the write clock domain. It does three things:
- accepts AXI-Stream beats;
- drives the dual-port memory write port;
- maintains the binary and Gray write pointers.

Its registered Gray write pointer is the source that feeds the read-domain pointer synchronizer. It consumes the already-synchronized Gray read pointer to generate full/back-pressure, fill level and almost-full.

## Interface
Parameters:
- DATA_WIDTH, 32, tdata width in bits
- ADDR_WIDTH, 4, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- ALMOST_FULL_THRESH, 12, level at or above which almost_full asserts (1..2^ADDR_WIDTH)

Ports:
- wr_clk  in  1  write-domain clock; the only clock
- wr_rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tlast  in  1  end-of-packet marker
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tready  out  1  FIFO not full; registered
- mem_wr_en  out  1  memory write strobe (combinational)
- mem_wr_addr  out  ADDR_WIDTH  memory write address
- mem_wr_data  out  DATA_WIDTH+1  {tlast, tdata}
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to synchronizer in the read domain
- rptr_gray_sync  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into wr_clk
- wr_level  out  ADDR_WIDTH+1  registered occupancy as seen by the write side, 0..2^ADDR_WIDTH
- almost_full  out  1  registered, wr_level >= ALMOST_FULL_THRESH

## Operation
**Handshake and memory write**
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- mem_wr_en is high exactly for an accepted beat.
- mem_wr_addr = wbin[ADDR_WIDTH-1:0].
- mem_wr_data = {s_axis_tlast, s_axis_tdata}.

**Pointer update**
- wbin_next = wbin + accept, modulo 2^(ADDR_WIDTH+1), so the pointer wraps naturally.
- wgray_next = wbin_next ^ (wbin_next >> 1).
- wbin and wptr_gray are registered from these values.
- wptr_gray is driven only from a flop: no combinational path to the output, and exactly one bit toggles per accept.

**Full**
- full_next is true when wgray_next equals rptr_gray_sync with its two MSBs inverted and the remaining bits equal.
- s_axis_tready <= !full_next.

**Level**
- rbin_sync = Gray-to-binary(rptr_gray_sync), combinational.
- wr_level <= wbin_next - rbin_sync, modulo 2^(ADDR_WIDTH+1).
- almost_full <= (wbin_next - rbin_sync) >= ALMOST_FULL_THRESH.

**Conservatism**
- Level and full are pessimistic: the read pointer lags by the synchronizer latency.
- Overflow is therefore impossible; underestimating free space is permitted.

**Reset**
- Asserting wr_rst, including mid-operation, immediately clears everything: wbin=0, wptr_gray=0, wr_level=0, almost_full=0, s_axis_tready=0, and hence mem_wr_en=0.
- In-flight memory contents are abandoned.
- The read domain must be reset in the same event.

## Timing
- s_axis_tready is 0 during reset and rises at the first wr_clk edge after wr_rst deasserts (rptr_gray_sync = 0 at that point).
- Write latency: the beat is presented to memory in the same cycle it is accepted. wptr_gray, wr_level and almost_full reflect it after the next wr_clk edge.
- Fill: s_axis_tready falls at the same edge that accepts the 2^ADDR_WIDTH-th unread beat. No beat is ever accepted while full.
- Release: a change on rptr_gray_sync shows up in s_axis_tready, wr_level and almost_full one edge later.
- Round trip: end-to-end free-space latency is this register plus the 3-stage synchronizer in the write domain.
- Simultaneous accept and rptr_gray_sync advance: both are applied in the same cycle, so the level is unchanged.
- Wrap-around: after 2^(ADDR_WIDTH+1) accepts, wbin and wptr_gray return to 0. Full detection is correct across the wrap via the MSB inversion rule.
- tready is independent of tvalid. tvalid may be held while tready is low with no side effect.

## Test plan
1. **Reset mid-stream:** at level 7, assert wr_rst asynchronously → tready=0, wptr_gray=0, wr_level=0, almost_full=0 without waiting for a clock edge. Release → tready=1 after the first edge.
2. **Fill** (ADDR_WIDTH=4, rptr_gray_sync held 0, tvalid=1 for 20 cycles) →
   - exactly 16 accepts, at addresses 0..15;
   - almost_full=1 at the edge of the 12th accept;
   - tready=0 at the edge of the 16th accept;
   - wptr_gray=5'b11000 and wr_level=16;
   - mem_wr_en stays 0 thereafter.
3. **Release from full:** set rptr_gray_sync=5'b00001 → next edge tready=1 and wr_level=15. The next accept writes address 0, then tready=0 and wr_level=16.
4. **Simultaneous events:** at level 10, one accept in the same cycle rptr_gray_sync advances by one → wr_level stays 10 and almost_full stays 0.
5. **Wrap-around:** stream 40 beats with rptr_gray_sync tracking wptr_gray delayed by 4 cycles →
   - every wptr_gray change flips exactly one bit;
   - wptr_gray returns to 0 after the 32nd accept;
   - tready never drops and addresses cycle 0..15.
6. **Payload and tvalid gaps:** beats with tlast=1 on beats 3 and 7, and tvalid gaps in between → mem_wr_data[DATA_WIDTH] matches tlast per beat, and no mem_wr_en pulses occur during gaps.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-domain half of the async AXI-Stream FIFO: accepts beats, drives the
// memory write port and publishes a registered Gray write pointer.
module fifo_wr_ctrl #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_THRESH = 12
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH:0]   mem_wr_data,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  almost_full
);

    localparam logic [ADDR_WIDTH:0] AF_TH     = ALMOST_FULL_THRESH[ADDR_WIDTH:0];
    // Full when the write pointer is exactly one lap ahead: in Gray that is
    // the two MSBs inverted relative to the read pointer.
    localparam logic [ADDR_WIDTH:0] FULL_MASK = {2'b11, {(ADDR_WIDTH-1){1'b0}}};

    logic                accept;
    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] wgray_next;
    logic [ADDR_WIDTH:0] rbin_sync;
    logic [ADDR_WIDTH:0] level_next;
    logic                full_next;

    for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_gray2bin
        assign rbin_sync[i] = ^rptr_gray_sync[ADDR_WIDTH:i];
    end

    always_comb begin
        accept     = s_axis_tvalid && s_axis_tready;
        wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, accept};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        level_next = wbin_next - rbin_sync;
        full_next  = (wgray_next == (rptr_gray_sync ^ FULL_MASK));
    end

    assign mem_wr_en   = accept;
    assign mem_wr_addr = wbin[ADDR_WIDTH-1:0];
    assign mem_wr_data = {s_axis_tlast, s_axis_tdata};

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin          <= '0;
            wptr_gray     <= '0;
            wr_level      <= '0;
            almost_full   <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            wptr_gray     <= wgray_next;
            wr_level      <= level_next;
            almost_full   <= (level_next >= AF_TH);
            s_axis_tready <= !full_next;
        end
    end

endmodule
